alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-003 a  input  32  operand A.
REQ-004 b  input  32  operand B; b[4:0] is the shift amount for shift ops.
REQ-005 alu_control  input  4  operation select, encoding per REQ-008.
REQ-006 alu_result  output  32  registered operation result.
REQ-007 zero  output  1  registered flag, 1 when alu_result == 0.

Function
REQ-008 Operation encoding SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SLT (signed)
- 1000 SLTU
- 1001 SRA
- 1100 NOR
REQ-009 Unlisted encodings SHALL produce result 0x00000000 (zero=1).
REQ-010 ADD/SUB SHALL be 32-bit modulo 2^32; carry/overflow discarded, no overflow flag.
REQ-011 SLT SHALL compare a, b as two's-complement; SLTU as unsigned; result 0x00000001 if a<b, else 0x00000000.
REQ-012 SLL/SRL SHALL shift a by b[4:0] with zero fill; SRA SHALL replicate a[31]; b[31:5] ignored.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on alu_result/zero after edge N.
REQ-014 Outputs SHALL update every cycle with no enable or handshake; new op accepted every cycle.
REQ-015 zero SHALL be computed from the same combinational result registered into alu_result, so both are always consistent.
REQ-016 X/undefined alu_control SHALL not be relied on; a case default SHALL drive 0.

Reset
REQ-017 While rst_n=0 at a rising edge, alu_result SHALL become 0x00000000 and zero SHALL become 1.
REQ-018 Reset SHALL take priority over any operation in the same cycle; the first valid result appears 1 cycle after the first edge with rst_n=1.
REQ-019 No asynchronous reset path SHALL exist.

Structure
REQ-020 A shared package alu_pkg SHALL hold the 4-bit operation encodings as a typedef enum, plus XLEN=32.
REQ-021 Shifter logic (SLL/SRL/SRA) SHALL be a sub-module alu_shifter; all other logic SHALL stay in alu.
REQ-022 Combinational result and registered stage SHALL be separate processes.

Verification
REQ-023 a=0x0000F0AE, b=0x00000FA1, then one op per cycle:
- AND -> 0x000000A0
- OR -> 0x0000FFAF
- ADD -> 0x0001004F
- SUB -> 0x0000E10D
- SLT -> 0x00000000 with zero=1
REQ-024 Swap operands (a=0x00000FA1, b=0x0000F0AE), SLT -> 0x00000001, zero=0; SUB -> 0xFFFF1EF3.
REQ-025 Signed vs unsigned: a=0x80000000, b=0x00000001.
- SLT -> 1, SLTU -> 0
- SRA with b=4 -> 0xF8000000
- SRL with b=4 -> 0x08000000
REQ-026 Wrap/zero: a=0xFFFFFFFF, b=1, ADD -> 0x00000000 with zero=1; a=b=0x12345678, SUB -> 0, zero=1.
REQ-027 Reset mid-stream: assert rst_n=0 while ADD is pending -> next edge alu_result=0, zero=1; release -> result 1 cycle later.
REQ-028 Unlisted encoding 1111 with a=b=0xFFFFFFFF -> 0x00000000, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: datapath width and the 4-bit operation encodings.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  // Zero detect shared by the result register and anything else that needs it.
  function automatic logic is_zero(input logic [XLEN-1:0] value);
    return (value == {XLEN{1'b0}});
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; any other operation yields zero.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [4:0]      i_shamt,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_result
);

  // Select the shift flavour for the current operation.
  always_comb begin
    o_result = {XLEN{1'b0}};
    case (alu_op_e'(i_op))
      OP_SLL:  o_result = i_a << i_shamt;
      OP_SRL:  o_result = i_a >> i_shamt;
      OP_SRA:  o_result = $unsigned($signed(i_a) >>> i_shamt);
      default: o_result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: combinational operation select followed by a result/zero register.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  alu_shifter u_shifter (
    .i_a      (a),
    .i_shamt  (b[4:0]),
    .i_op     (alu_control),
    .o_result (w_shift)
  );

  // Operation select; unlisted encodings deliberately produce zero.
  always_comb begin
    w_result = {XLEN{1'b0}};
    case (alu_op_e'(alu_control))
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_ADD:  w_result = a + b;
      OP_XOR:  w_result = a ^ b;
      OP_SUB:  w_result = a - b;
      OP_NOR:  w_result = ~(a | b);
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: w_result = w_shift;
      default: w_result = {XLEN{1'b0}};
    endcase
  end

  // Result register; zero is taken from the same value so the two never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= {XLEN{1'b0}};
      r_zero   <= 1'b1;
    end else begin
      r_result <= w_result;
      r_zero   <= is_zero(w_result);
    end
  end

  assign alu_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with known answers, then random ops against a reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model written straight from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    longint sx, sy;
    logic [63:0] ext;
    sh = y % 32;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ext = {{32{x[31]}}, x};
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
      4'd3:  return x ^ y;
      4'd4:  return 32'(64'(x) * (64'd1 << sh));
      4'd5:  return 32'(64'(x) / (64'd1 << sh));
      4'd6:  return 32'((64'h1_0000_0000 + 64'(x) - 64'(y)) % 64'h1_0000_0000);
      4'd7:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  return (64'(x) < 64'(y)) ? 32'd1 : 32'd0;
      4'd9:  return 32'(ext >> sh);
      4'd12: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  // Apply one operation, let one edge pass, then compare result and zero flag.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    alu_control = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, alu_result, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    rst_n = 1'b0;
    alu_control = 4'b0010;
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_result", alu_result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;

    run_op("and",  4'b0000, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_00A0);
    run_op("or",   4'b0001, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_FFAF);
    run_op("add",  4'b0010, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0001_004F);
    run_op("sub",  4'b0110, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_E10D);
    run_op("slt",  4'b0111, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_0000);
    run_op("slt_swap", 4'b0111, 32'h0000_0FA1, 32'h0000_F0AE, 32'h0000_0001);
    run_op("sub_swap", 4'b0110, 32'h0000_0FA1, 32'h0000_F0AE, 32'hFFFF_1EF3);
    run_op("slt_neg",  4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
    run_op("sltu_big", 4'b1000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000);
    run_op("sra4", 4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    run_op("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    run_op("sll_hi_b", 4'b0100, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006);
    run_op("xor",  4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    run_op("nor",  4'b1100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h00F0_00F0);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    run_op("sub_eq",   4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    run_op("unlisted", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    // Reset mid-stream: an ADD is presented while rst_n is low.
    alu_control = 4'b0010;
    a = 32'h0000_0010;
    b = 32'h0000_0020;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_result", alu_result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    run_op("post_rst_add", 4'b0010, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

    for (int i = 0; i < 300; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 7 == 0) r_b = r_a;
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, ref_alu(r_op, r_a, r_b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
